// File: rtl/ntt_pkg.sv
// Shared constants, butterfly mode encodings and FSM state encoding for the
// Kyber NTT/INTT sequencer.
package ntt_pkg;

  localparam int N      = 256;
  localparam int LOGN   = 8;
  localparam int LAYERS = 7;
  localparam int PAIRS  = 128;

  localparam logic [1:0] MODE_NTT  = 2'b00;
  localparam logic [1:0] MODE_INTT = 2'b01;
  localparam logic [1:0] MODE_BP   = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  typedef logic [1:0] ntt_state_t;

  localparam ntt_state_t S_IDLE  = 2'd0;
  localparam ntt_state_t S_RUN   = 2'd1;
  localparam ntt_state_t S_DRAIN = 2'd2;
  localparam ntt_state_t S_FIN   = 2'd3;

endpackage

// File: rtl/ntt_addr_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} from read issue
// to butterfly write-back; rst clears every stage so pending writes are dropped.
module ntt_addr_delay #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
  output logic          out_valid,
  output logic [AW-1:0] out_addr_a,
  output logic [AW-1:0] out_addr_b
);

  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    a_q [DEPTH];
  logic [AW-1:0]    b_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      a_q[0]   <= in_addr_a;
      b_q[0]   <= in_addr_b;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        a_q[i]   <= a_q[i-1];
        b_q[i]   <= b_q[i-1];
      end
    end
  end

  assign out_valid  = vld_q[DEPTH-1];
  assign out_addr_a = a_q[DEPTH-1];
  assign out_addr_b = b_q[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// Kyber NTT/INTT sequencer: issues butterfly read pairs layer by layer and
// writes results back in place. Optional cycle counter: NTT_CTRL_CYCCNT_EN.
//
// Handshake: start is a one-cycle request honoured only when idle (inverse is
// sampled with it); busy stays high until the transform ends, then done
// pulses for exactly one cycle. rd_en/wr_en are unconditional strobes (no
// back-pressure): the RAM and butterfly must accept every issued pair.
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inverse,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] tw_addr,
  output logic [1:0] bf_mode,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
`ifdef NTT_CTRL_CYCCNT_EN
  output logic [15:0] cyc_cnt,
`endif
  output ntt_state_t state_dbg
);

  localparam int         LAT        = RD_LAT + BF_LAT;
  localparam logic [7:0] DRAIN_LAST = 8'(LAT - 1);

  ntt_state_t state;
  logic       inv_q;
  logic [2:0] lg;         // log2(len) of the current layer
  logic [2:0] layer;
  logic [7:0] base;       // group start s
  logic [6:0] j_off;      // j - s within the group
  logic [6:0] issue;
  logic [6:0] k;
  logic [7:0] drain_cnt;

  logic [7:0] len;
  logic [7:0] addr_a;
  logic [8:0] base_next;
  logic       grp_last;

  always_comb begin
    len       = 8'd1 << lg;
    addr_a    = base + {1'b0, j_off};
    grp_last  = ({1'b0, j_off} == (len - 8'd1));
    base_next = {1'b0, base} + {len, 1'b0};
  end

  assign rd_en     = (state == S_RUN);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_FIN);
  assign rd_addr_a = rd_en ? addr_a : 8'd0;
  assign rd_addr_b = rd_en ? (addr_a + len) : 8'd0;
  assign tw_addr   = rd_en ? k : 7'd0;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      inv_q     <= 1'b0;
      lg        <= 3'd0;
      layer     <= 3'd0;
      base      <= 8'd0;
      j_off     <= 7'd0;
      issue     <= 7'd0;
      k         <= 7'd0;
      drain_cnt <= 8'd0;
      bf_mode   <= MODE_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            inv_q     <= inverse;
            bf_mode   <= inverse ? MODE_INTT : MODE_NTT;
            lg        <= inverse ? 3'd1 : 3'd7;
            k         <= inverse ? 7'd127 : 7'd1;
            layer     <= 3'd0;
            base      <= 8'd0;
            j_off     <= 7'd0;
            issue     <= 7'd0;
            drain_cnt <= 8'd0;
          end
        end
        S_RUN: begin
          issue <= issue + 7'd1;
          if (grp_last) begin
            j_off <= 7'd0;
            base  <= base_next[7:0];
            k     <= inv_q ? (k - 7'd1) : (k + 7'd1);
          end else begin
            j_off <= j_off + 7'd1;
          end
          if (issue == 7'(PAIRS - 1)) begin
            state     <= S_DRAIN;
            base      <= 8'd0;
            drain_cnt <= 8'd0;
          end
        end
        S_DRAIN: begin
          // Hold off the next layer until its predecessor's last write lands.
          if (drain_cnt == DRAIN_LAST) begin
            layer <= layer + 3'd1;
            lg    <= inv_q ? (lg + 3'd1) : (lg - 3'd1);
            state <= (layer == 3'(LAYERS - 1)) ? S_FIN : S_RUN;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        S_FIN: begin
          bf_mode <= MODE_IDLE;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NTT_CTRL_CYCCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= 16'd0;
    end else if ((state == S_IDLE) && start) begin
      cyc_cnt <= 16'd0;
    end else if (busy) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end
`endif

  ntt_addr_delay #(
    .DEPTH(LAT),
    .AW   (8)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_addr_a (rd_addr_a),
    .in_addr_b (rd_addr_b),
    .out_valid (wr_en),
    .out_addr_a(wr_addr_a),
    .out_addr_b(wr_addr_b)
  );

endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: an independent loop-nest model fills
// read/write scoreboards with cycle-stamped expectations; a negedge monitor pops them.
module tb_ntt_ctrl;
  import ntt_pkg::*;

  localparam int RD_W = 55;  // {cyc[31:0], a[7:0], b[7:0], k[6:0]}
  localparam int WR_W = 48;  // {cyc[31:0], a[7:0], b[7:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        inverse;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [7:0]  rd_addr_a;
  logic [7:0]  rd_addr_b;
  logic [6:0]  tw_addr;
  logic [1:0]  bf_mode;
  logic        wr_en;
  logic [7:0]  wr_addr_a;
  logic [7:0]  wr_addr_b;
  ntt_state_t  state_dbg;
`ifdef NTT_CTRL_CYCCNT_EN
  logic [15:0] cyc_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  logic        mon_en = 1'b0;
  logic        run_active = 1'b0;
  int unsigned exp_busy_lo, exp_busy_hi, exp_done_cyc;
  logic [1:0]  exp_mode;
  int          done_cnt;
  int unsigned last_done_cyc;

  logic [RD_W-1:0] exp_rd_q[$];
  logic [WR_W-1:0] exp_wr_q[$];
  logic [RD_W-1:0] rd_item;
  logic [WR_W-1:0] wr_item;
  logic            exp_rd, exp_wr, exp_b, exp_d;

  ntt_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inverse  (inverse),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .bf_mode  (bf_mode),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b),
`ifdef NTT_CTRL_CYCCNT_EN
    .cyc_cnt  (cyc_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // Clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: Kyber loop nest with LAT = 4 and a 4-cycle drain per layer
  task automatic build_expected(input logic inv, input int unsigned c0);
    int unsigned t;
    int k;
    int len;
    t = c0 + 1;
    k = inv ? 127 : 1;
    for (int l = 0; l < 7; l++) begin
      len = inv ? (2 << l) : (128 >> l);
      for (int s = 0; s < 256; s += 2 * len) begin
        for (int j = s; j < s + len; j++) begin
          exp_rd_q.push_back({t, 8'(j), 8'(j + len), 7'(k)});
          exp_wr_q.push_back({t + 32'd4, 8'(j), 8'(j + len)});
          t++;
        end
        k = inv ? k - 1 : k + 1;
      end
      t += 4;
    end
    exp_busy_lo  = c0 + 1;
    exp_busy_hi  = c0 + 924;
    exp_done_cyc = c0 + 925;
    exp_mode     = inv ? MODE_INTT : MODE_NTT;
    done_cnt     = 0;
    run_active   = 1'b1;
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      exp_rd = (exp_rd_q.size() > 0) && (exp_rd_q[0][54:23] == cyc);
      checks++;
      if (rd_en !== exp_rd) begin
        errors++;
        $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd);
      end
      if (exp_rd) begin
        rd_item = exp_rd_q.pop_front();
        checks++;
        if ({rd_addr_a, rd_addr_b, tw_addr} !== rd_item[22:0]) begin
          errors++;
          $display("FAIL rd_pair cyc=%0d got=(%0d,%0d,k%0d) exp=(%0d,%0d,k%0d)", cyc,
                   rd_addr_a, rd_addr_b, tw_addr, rd_item[22:15], rd_item[14:7], rd_item[6:0]);
        end
      end
      exp_wr = (exp_wr_q.size() > 0) && (exp_wr_q[0][47:16] == cyc);
      checks++;
      if (wr_en !== exp_wr) begin
        errors++;
        $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr_en, exp_wr);
      end
      if (exp_wr) begin
        wr_item = exp_wr_q.pop_front();
        checks++;
        if ({wr_addr_a, wr_addr_b} !== wr_item[15:0]) begin
          errors++;
          $display("FAIL wr_addr cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc,
                   wr_addr_a, wr_addr_b, wr_item[15:8], wr_item[7:0]);
        end
      end
      exp_b = run_active && (cyc >= exp_busy_lo) && (cyc <= exp_busy_hi);
      exp_d = run_active && (cyc == exp_done_cyc);
      checks++;
      if ((busy !== exp_b) || (done !== exp_d)) begin
        errors++;
        $display("FAIL busy_done cyc=%0d got=%b%b exp=%b%b", cyc, busy, done, exp_b, exp_d);
      end
      if (exp_b || !run_active) begin
        checks++;
        if (bf_mode !== (exp_b ? exp_mode : MODE_IDLE)) begin
          errors++;
          $display("FAIL bf_mode cyc=%0d got=%b exp=%b", cyc, bf_mode,
                   exp_b ? exp_mode : MODE_IDLE);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (exp_d) run_active = 1'b0;
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    inverse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=0000", {busy, done, rd_en, wr_en});
    end
    checks++;
    if ({rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 39'd0) begin
      errors++;
      $display("FAIL reset_addrs got=%h exp=0", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    end
    checks++;
    if ({bf_mode, state_dbg} !== {MODE_IDLE, S_IDLE}) begin
      errors++;
      $display("FAIL reset_mode_state got=%b/%0d exp=11/%0d", bf_mode, state_dbg, S_IDLE);
    end
`ifdef NTT_CTRL_CYCCNT_EN
    checks++;
    if (cyc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cyc_cnt got=%0d exp=0", cyc_cnt);
    end
`endif
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full transform; optionally pulses start again at cycle 300 while busy
  task automatic run_transform(input logic inv, input logic pulse_busy, input string name);
    int unsigned c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    build_expected(inv, c0);
    start = 1'b1;
    inverse = inv;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < c0 + 930) begin
      start = pulse_busy && (cyc == c0 + 300);
      inverse = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if ((done_cnt !== 1) || (last_done_cyc !== c0 + 925)) begin
      errors++;
      $display("FAIL %s_done count=%0d at=%0d exp=1 at=%0d", name, done_cnt,
               last_done_cyc - c0, 925);
    end
    checks++;
    if ((exp_rd_q.size() != 0) || (exp_wr_q.size() != 0)) begin
      errors++;
      $display("FAIL %s_drain rd_left=%0d wr_left=%0d exp=0/0", name,
               exp_rd_q.size(), exp_wr_q.size());
    end
`ifdef NTT_CTRL_CYCCNT_EN
    checks++;
    if (cyc_cnt !== 16'd924) begin
      errors++;
      $display("FAIL %s_cyc_cnt got=%0d exp=924", name, cyc_cnt);
    end
`endif
  endtask

  task automatic test_ntt;
    run_transform(1'b0, 1'b0, "ntt");
  endtask

  task automatic test_intt;
    run_transform(1'b1, 1'b0, "intt");
  endtask

  task automatic test_start_while_busy;
    run_transform(1'b0, 1'b1, "busy_start");
  endtask

  task automatic test_reset_mid;
    int unsigned c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    build_expected(1'b0, c0);
    start = 1'b1;
    inverse = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < c0 + 500) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
    run_active = 1'b0;
    checks++;
    if ({busy, wr_en, bf_mode} !== {1'b0, 1'b0, MODE_IDLE}) begin
      errors++;
      $display("FAIL rst_mid got=busy%b wr%b mode%b exp=busy0 wr0 mode11", busy, wr_en, bf_mode);
    end
    repeat (5) @(posedge clk);
    #1;
    run_transform(1'b0, 1'b0, "post_rst");
  endtask

  task automatic test_rst_start_same;
    @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if ((busy !== 1'b0) || (state_dbg !== S_IDLE)) begin
      errors++;
      $display("FAIL rst_start got=busy%b state%0d exp=busy0 state%0d", busy, state_dbg, S_IDLE);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_ntt();
    test_intt();
    test_start_while_busy();
    test_reset_mid();
    test_rst_start_same();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
